// File: rtl/arm_instr_encoder_if.sv
// -----------------------------------------------------------------------------
// arm_instr_encoder_if
//   Bundles the two handshakes of the ARMv4 instruction encoder.
//   Request side : in_valid/in_ready plus the instruction fields
//                  (in_op, in_cond, in_funct, in_rn, in_rd, in_src2, in_imm24).
//   Memory side  : mem_we/mem_ready write port carrying mem_addr/mem_wdata.
//   Modports     : master = program source / instruction memory (bench side)
//                  slave  = the encoder itself
// -----------------------------------------------------------------------------
interface arm_instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [3:0]        in_cond;
    logic [5:0]        in_funct;
    logic [3:0]        in_rn;
    logic [3:0]        in_rd;
    logic [11:0]       in_src2;
    logic [23:0]       in_imm24;

    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_op, in_cond, in_funct, in_rn, in_rd, in_src2, in_imm24,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_ready
    );

    modport slave (
        input  in_valid, in_op, in_cond, in_funct, in_rn, in_rd, in_src2, in_imm24,
        output in_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_ready
    );
endinterface

// File: rtl/arm_instr_encoder.sv
// -----------------------------------------------------------------------------
// arm_instr_encoder
//   Assembles ARMv4 machine words from instruction fields, queues them in a
//   small FIFO and writes them to instruction memory at consecutive word
//   addresses through a stallable write port. Used as the program loader.
//
//   Ports:
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     restart      synchronous flush: FIFO, address and counters cleared
//     bus          arm_instr_encoder_if.slave (request + memory write port)
//     word_count   words written since reset/restart (wraps at 2^16)
//     err_count    rejected requests (saturates at 255)
//     idle         FIFO empty and no request pending
//
//   Optional feature macro: ARM_ENC_CHECK_EN
//     Defined   : requests the processor's decoder cannot execute are consumed,
//                 dropped and counted in err_count.
//     Undefined : every accepted request is encoded; err_count is tied to 0.
// -----------------------------------------------------------------------------
module arm_instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       restart,
    arm_instr_encoder_if.slave         bus,
    output logic [15:0]                word_count,
    output logic [7:0]                 err_count,
    output logic                       idle
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_run;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_word_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_legal;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_word;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);

    // r_run holds in_ready low during reset and releases it on the first edge
    // after rst_n deasserts. A full FIFO refuses even when it pops this cycle.
    assign bus.in_ready = r_run & ~w_full & ~restart;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_push       = w_accept & w_legal;
    assign w_pop        = ~w_empty & bus.mem_ready;

    // Field assembly; op 11 falls through to the DP/MEM layout with its own op bits.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_word = {bus.in_cond, bus.in_op, bus.in_funct, bus.in_rn, bus.in_rd, bus.in_src2};
        if (bus.in_op == 2'b10) begin
            w_word = {bus.in_cond, 2'b10, bus.in_funct[5:4], bus.in_imm24};
        end
    end

`ifdef ARM_ENC_CHECK_EN
    logic [7:0] r_err_cnt;
    logic [3:0] w_cmd;

    // DP funct is {I, cmd[3:0], S}; shift type sits in src2[6:5].
    assign w_cmd = bus.in_funct[4:1];

    always_comb begin
        w_legal = 1'b1;
        if (bus.in_op == 2'b11) begin
            w_legal = 1'b0;
        end else if (bus.in_op == 2'b00) begin
            case (w_cmd)
                4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1100, 4'b1111: w_legal = 1'b1;
                4'b1101: w_legal = ~bus.in_funct[5] & (bus.in_src2[6:5] == 2'b11); // MOV
                4'b1010: w_legal = bus.in_funct[0];                                 // CMP
                default: w_legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (restart) begin
            r_err_cnt <= '0;
        end else if (w_accept && !w_legal && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign w_legal   = 1'b1;
    assign err_count = '0;
`endif

    // NOTE: the FIFO storage has no reset; occupancy and pointers are reset, so
    // stale entries are never visible and the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_push && !restart) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_addr     <= BASE_ADDR;
            r_word_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            if (restart) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_addr     <= BASE_ADDR;
                r_word_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                    r_addr     <= r_addr + ADDR_W'(4);
                    r_word_cnt <= r_word_cnt + 16'd1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                    2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.mem_we    = ~w_empty;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = w_empty ? 32'd0 : r_mem[r_rd_ptr];
    assign word_count    = r_word_cnt;
    assign idle          = w_empty & ~bus.in_valid;

endmodule
